// File: rtl/divconst_seq.sv
// Multi-cycle divide-by-constant: restoring division, STEP quotient bits per clock,
// with unsigned, signed-floor and signed-truncate result semantics.
module divconst_seq #(
  parameter int WIDTH   = 32,
  parameter int DIVISOR = 10,
  parameter int STEP    = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic             is_signed,
  input  logic             floor_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int N  = WIDTH / STEP;
  localparam int RW = $clog2(DIVISOR);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [RW:0]      DIV_R = (RW+1)'(DIVISOR);
  localparam logic [WIDTH-1:0] DIV_W = WIDTH'(DIVISOR);
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);

  if (WIDTH < 8) begin : g_bad_width
    $error("divconst_seq: WIDTH must be at least 8");
  end
  if (WIDTH % STEP != 0) begin : g_bad_step
    $error("divconst_seq: WIDTH must be a multiple of STEP");
  end
  if (DIVISOR < 2 || $clog2(DIVISOR + 1) > WIDTH - 1) begin : g_bad_div
    $error("divconst_seq: DIVISOR out of range");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] q_q, r_q;

  logic [WIDTH-1:0] mag_q, mag_d;
  logic [RW:0]      rem_q, rem_d;
  logic             neg_q, floor_q;

  logic             accept;
  logic [WIDTH-1:0] rm_w;
  logic [WIDTH-1:0] fix_q, fix_r;

  assign in_ready  = rstn && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;

  // STEP chained restoring steps; quotient bits enter the magnitude register from the LSB
  always_comb begin
    rem_d = rem_q;
    mag_d = mag_q;
    for (int i = 0; i < STEP; i++) begin
      rem_d = {rem_d[RW-1:0], mag_d[WIDTH-1]};
      mag_d = {mag_d[WIDTH-2:0], 1'b0};
      if (rem_d >= DIV_R) begin
        rem_d    = rem_d - DIV_R;
        mag_d[0] = 1'b1;
      end
    end
  end

  assign rm_w = WIDTH'(rem_q);

  // Floor with a nonzero remainder rounds the magnitude up: -(qm+1) == ~qm
  always_comb begin
    fix_q = mag_q;
    fix_r = rm_w;
    if (neg_q) begin
      if (!floor_q || rem_q == '0) begin
        fix_q = -mag_q;
        fix_r = -rm_w;
      end else begin
        fix_q = ~mag_q;
        fix_r = DIV_W - rm_w;
      end
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
    end else if (accept) begin
      state_q     <= CALC;
      cnt_q       <= CNT_LAST;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          q_q         <= fix_q;
          r_q         <= fix_r;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q   <= is_signed && num[WIDTH-1];
      mag_q   <= (is_signed && num[WIDTH-1]) ? (~num + 1'b1) : num;
      floor_q <= floor_mode;
      rem_q   <= '0;
    end else if (state_q == CALC) begin
      mag_q <= mag_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: tb/tb_divconst_seq.sv
// Bench for divconst_seq: vector table through a scoreboard, plus backpressure,
// reset and alternate-parameter sequences.
module tb_divconst_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid, in_ready, is_signed, floor_mode, out_valid, out_ready;
  logic [31:0] num, q, r;

  logic        in_valid4, in_ready4, out_valid4;
  logic [31:0] num4, q4, r4;
  logic        in_valid7, in_ready7, out_valid7, floor7;
  logic [15:0] num7, q7, r7;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {logic [31:0] q; logic [31:0] r;} exp_t;
  typedef struct {
    logic [31:0] n;
    logic        s;
    logic        f;
    logic [31:0] eq;
    logic [31:0] er;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[11];

  always #5 clk = ~clk;

  divconst_seq #(.WIDTH(32), .DIVISOR(10), .STEP(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .num(num),
    .is_signed(is_signed), .floor_mode(floor_mode), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .r(r)
  );

  divconst_seq #(.WIDTH(32), .DIVISOR(10), .STEP(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4), .num(num4),
    .is_signed(1'b0), .floor_mode(1'b0), .out_valid(out_valid4),
    .out_ready(1'b1), .q(q4), .r(r4)
  );

  divconst_seq #(.WIDTH(16), .DIVISOR(7), .STEP(1)) dut7 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid7), .in_ready(in_ready7), .num(num7),
    .is_signed(1'b1), .floor_mode(floor7), .out_valid(out_valid7),
    .out_ready(1'b1), .q(q7), .r(r7)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
  endtask

  // Each negedge with both handshake signals high is exactly one transfer
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got q=0x%08h r=0x%08h, want no output", q, r);
      end else begin
        mon_e = sb.pop_front();
        check("q", q, mon_e.q);
        check("r", r, mon_e.r);
      end
    end
  end

  task automatic send(input logic [31:0] n, input logic s, input logic f,
                      input logic [31:0] eq, input logic [31:0] er);
    int guard = 0;
    num = n; is_signed = s; floor_mode = f; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 32'(guard), 32'd0);
    sb.push_back('{eq, er});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int lat);
    int cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 32'(cyc), 32'(lat));
  endtask

  task automatic run4(input logic [31:0] n, input logic [31:0] eq, input logic [31:0] er);
    int cyc = 0;
    num4 = n; in_valid4 = 1'b1;
    check("s4_in_ready", {31'd0, in_ready4}, 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    while (!out_valid4 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s4_latency", 32'(cyc), 32'd9);
    check("s4_q", q4, eq);
    check("s4_r", r4, er);
    @(posedge clk); #1;
  endtask

  task automatic run7(input logic [15:0] n, input logic f, input logic [15:0] eq, input logic [15:0] er);
    int cyc = 0;
    num7 = n; floor7 = f; in_valid7 = 1'b1;
    check("d7_in_ready", {31'd0, in_ready7}, 32'd1);
    @(posedge clk); #1;
    in_valid7 = 1'b0;
    while (!out_valid7 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("d7_latency", 32'(cyc), 32'd17);
    check("d7_q", {16'd0, q7}, {16'd0, eq});
    check("d7_r", {16'd0, r7}, {16'd0, er});
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'd12345,      1'b0, 1'b0, 32'd1234,      32'd5};
    vecs[1]  = '{32'hFFFF_FFF9,  1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3};
    vecs[2]  = '{32'hFFFF_FFF9,  1'b1, 1'b0, 32'd0,         32'hFFFF_FFF9};
    vecs[3]  = '{32'hFFFF_FFEC,  1'b1, 1'b1, 32'hFFFF_FFFE, 32'd0};
    vecs[4]  = '{32'h8000_0000,  1'b1, 1'b1, 32'hF333_3333, 32'd2};
    vecs[5]  = '{32'h8000_0000,  1'b1, 1'b0, 32'hF333_3334, 32'hFFFF_FFF8};
    vecs[6]  = '{32'h8000_0000,  1'b0, 1'b1, 32'h0CCC_CCCC, 32'd8};
    vecs[7]  = '{32'd0,          1'b0, 1'b0, 32'd0,         32'd0};
    vecs[8]  = '{32'hFFFF_FFFF,  1'b0, 1'b0, 32'd429496729, 32'd5};
    vecs[9]  = '{32'd9,          1'b1, 1'b1, 32'd0,         32'd9};
    vecs[10] = '{32'hFFFF_FFF6,  1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0};

    in_valid = 1'b0; num = '0; is_signed = 1'b0; floor_mode = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; num4 = '0; in_valid7 = 1'b0; num7 = '0; floor7 = 1'b0;

    #3 rstn = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].n, vecs[i].s, vecs[i].f, vecs[i].eq, vecs[i].er);
      wait_result("latency", 33);
      @(posedge clk); #1;
    end

    // Backpressure in DONE, then same-edge accept of the next operand
    out_ready = 1'b0;
    send(32'd7, 1'b0, 1'b0, 32'd0, 32'd7);
    wait_result("bp_latency", 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_q", q, 32'd0);
      check("bp_r", r, 32'd7);
    end
    num = 32'd99; is_signed = 1'b0; floor_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back('{32'd9, 32'd9});
    #1 check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_out_valid_clear", {31'd0, out_valid}, 32'd0);
    wait_result("b2b_latency", 33);
    @(posedge clk); #1;

    // Reset dropped mid-CALC discards the operation
    send(32'd12345, 1'b0, 1'b0, 32'd1234, 32'd5);
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1 check("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'd100, 1'b0, 1'b0, 32'd10, 32'd0);
    wait_result("midrst_latency", 33);
    repeat (4) @(posedge clk);
    #1 check("queue_drained", 32'(sb.size()), 32'd0);

    run4(32'hFFFF_FFFF, 32'd429496729, 32'd5);
    run7(16'hFFFF, 1'b1, 16'hFFFF, 16'd6);
    run7(16'hFFFF, 1'b0, 16'h0000, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
